// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: bus-mode encodings, lane helpers,
// clock-mode derivation and the FSM state/debug types.
package spi_pkg;

  localparam logic [1:0] BUS_SINGLE = 2'd0;
  localparam logic [1:0] BUS_DUAL   = 2'd1;
  localparam logic [1:0] BUS_QUAD   = 2'd2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Debug view of the slave FSM for checkers and waveform inspection.
  typedef struct packed {
    state_t     state;
    logic [3:0] sio_oe;
    logic [2:0] bit_cnt;
  } dbg_t;

  // Number of SIO lanes carrying data per edge (1/2/4); mode 3 is also quad.
  function automatic logic [2:0] lanes_per_mode(input logic [1:0] mode);
    case (mode)
      BUS_SINGLE: return 3'd1;
      BUS_DUAL:   return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  // Sampling edges needed to complete one byte.
  function automatic logic [3:0] edges_per_byte(input logic [1:0] mode);
    case (mode)
      BUS_SINGLE: return 4'd8;
      BUS_DUAL:   return 4'd4;
      default:    return 4'd2;
    endcase
  endfunction

  function automatic logic cpol_of(input int spi_mode);
    return (spi_mode == 2) || (spi_mode == 3);
  endfunction

  function automatic logic cpha_of(input int spi_mode);
    return (spi_mode == 1) || (spi_mode == 3);
  endfunction

  // MSb-first lane values for the next edge; single mode drives MISO on SIO[1].
  function automatic logic [3:0] lane_bits(input logic [1:0] mode, input logic [7:0] data);
    case (mode)
      BUS_SINGLE: return {2'b00, data[7], 1'b0};
      BUS_DUAL:   return {2'b00, data[7:6]};
      default:    return data[7:4];
    endcase
  endfunction

  // Lanes the slave owns for a byte, chosen at byte start.
  function automatic logic [3:0] lane_oe(input logic [1:0] mode, input logic dir);
    case (mode)
      BUS_SINGLE: return 4'b0010;
      BUS_DUAL:   return dir ? 4'b0011 : 4'b0000;
      default:    return dir ? 4'b1111 : 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_sync_2ff.sv
// Two-flop synchronizer bank for asynchronous SPI pins.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [WIDTH-1:0] i_D,
  output logic [WIDTH-1:0] o_Q
);

  logic [WIDTH-1:0] meta_q;

  // Two register stages; reset value matches the idle level of each pin.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta_q <= RST_VAL;
      o_Q    <= RST_VAL;
    end else begin
      meta_q <= i_D;
      o_Q    <= meta_q;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI target in the system clock domain: oversampled SPI pins, single/dual/
// quad byte shifting, byte-wide RX/TX handshakes toward local logic.
// Handshake: a TX byte is taken on any cycle where i_TX_DV=1 and o_TX_Ready=1;
// o_RX_DV and o_TX_Underrun are single-cycle pulses with no backpressure.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [1:0] i_Bus_Mode,
  input  logic       i_Lane_Dir,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  output logic       o_Busy,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  inout  wire  [3:0] SIO,
  output dbg_t       o_Dbg
);

  localparam logic       CPOL     = cpol_of(SPI_MODE);
  localparam logic       CPHA     = cpha_of(SPI_MODE);
  localparam logic [5:0] SYNC_RST = {CPOL, 1'b1, 4'b0000};

  logic [5:0] sync_q;
  logic       s_clk, s_cs;
  logic [3:0] s_sio;
  logic       clk_q, cs_q;
  state_t     state, state_nxt;
  logic [1:0] mode_q, cur_mode;
  logic       dir_q;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, rx_next, tx_shift, hold_q, tx_load_val;
  logic       hold_full;
  logic [3:0] sio_out, sio_oe;
  logic       lead_edge, trail_edge, sample_edge, drive_edge, cs_fall;
  logic       start_first, active, do_sample, do_drive, byte_end, byte_start, tx_accept;

  // Clock, CS and lanes share one synchronizer so data stays aligned with clock.
  sync_2ff #(.WIDTH(6), .RST_VAL(SYNC_RST)) u_sync (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_D   ({i_SPI_Clk, i_SPI_CS_n, SIO}),
    .o_Q   (sync_q)
  );

  assign s_clk = sync_q[5];
  assign s_cs  = sync_q[4];
  assign s_sio = sync_q[3:0];

  // Previous synchronized clock/CS for edge detection.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      clk_q <= CPOL;
      cs_q  <= 1'b1;
    end else begin
      clk_q <= s_clk;
      cs_q  <= s_cs;
    end
  end

  assign lead_edge   = CPOL ? (~s_clk & clk_q) : (s_clk & ~clk_q);
  assign trail_edge  = CPOL ? (s_clk & ~clk_q) : (~s_clk & clk_q);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = ~s_cs & cs_q;

  // State register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: enter on CS fall, leave on CS high from any point in a byte.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cs_fall) state_nxt = S_SHIFT;
      S_SHIFT: if (s_cs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign start_first = (state == S_IDLE) && cs_fall;
  assign active      = (state == S_SHIFT) && !s_cs;
  assign do_sample   = active && sample_edge;
  assign do_drive    = active && drive_edge;
  assign byte_end    = do_sample && (bit_cnt == lanes_per_mode(mode_q) - 3'd1);
  assign byte_start  = start_first || byte_end;
  assign cur_mode    = start_first ? i_Bus_Mode : mode_q;
  assign tx_load_val = hold_full ? hold_q : 8'hFF;
  assign tx_accept   = i_TX_DV && !hold_full;
  assign o_TX_Ready  = !hold_full;
  assign o_Busy      = (state == S_SHIFT);

  // Sampled lane bits appended MSb-first into the receive shifter.
  always_comb begin
    rx_next = {rx_shift[3:0], s_sio};
    case (mode_q)
      BUS_SINGLE: rx_next = {rx_shift[6:0], s_sio[0]};
      BUS_DUAL:   rx_next = {rx_shift[5:0], s_sio[1:0]};
      default:    rx_next = {rx_shift[3:0], s_sio};
    endcase
  end

  // TX holding register: a byte loaded on the transfer cycle stays for the next byte.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hold_q    <= 8'h00;
      hold_full <= 1'b0;
    end else if (tx_accept) begin
      hold_q    <= i_TX_Byte;
      hold_full <= 1'b1;
    end else if (byte_start) begin
      hold_full <= 1'b0;
    end
  end

  // Shift datapath, lane drive and byte-start bookkeeping.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_q        <= BUS_SINGLE;
      dir_q         <= 1'b0;
      bit_cnt       <= 3'd7;
      rx_shift      <= 8'h00;
      tx_shift      <= 8'h00;
      sio_out       <= 4'h0;
      sio_oe        <= 4'h0;
      o_RX_Byte     <= 8'h00;
      o_RX_DV       <= 1'b0;
      o_TX_Underrun <= 1'b0;
    end else begin
      o_RX_DV       <= 1'b0;
      o_TX_Underrun <= 1'b0;
      if (state == S_IDLE || s_cs) begin
        bit_cnt  <= 3'd7;
        rx_shift <= 8'h00;
        tx_shift <= 8'h00;
        sio_oe   <= 4'h0;
        if (start_first) mode_q <= i_Bus_Mode;
      end else begin
        if (do_sample) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt - lanes_per_mode(mode_q);
        end
        if (byte_end && !(mode_q != BUS_SINGLE && dir_q)) begin
          o_RX_Byte <= rx_next;
          o_RX_DV   <= 1'b1;
        end
        if (do_drive) begin
          sio_out  <= lane_bits(mode_q, tx_shift);
          tx_shift <= tx_shift << lanes_per_mode(mode_q);
        end
      end
      if (byte_start) begin
        dir_q         <= i_Lane_Dir;
        o_TX_Underrun <= !hold_full;
        sio_oe        <= lane_oe(cur_mode, i_Lane_Dir);
        if (start_first && !CPHA) begin
          sio_out  <= lane_bits(cur_mode, tx_load_val);
          tx_shift <= tx_load_val << lanes_per_mode(cur_mode);
        end else begin
          tx_shift <= tx_load_val;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sio
    assign SIO[g] = sio_oe[g] ? sio_out[g] : 1'bz;
  end

  assign o_Dbg = '{state: state, sio_oe: sio_oe, bit_cnt: bit_cnt};

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance in SPI mode 0, one in SPI mode 3,
// each driven by a bit-level master task; received bytes go through a scoreboard.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][1:0] bus_mode;
  logic [1:0]      lane_dir, tx_dv, spi_clk, cs_n;
  logic [1:0][7:0] tx_byte, rx_byte;
  logic [1:0]      tx_ready, underrun, rx_dv, busy;
  logic [1:0][3:0] m_out, m_oe;
  wire  [3:0]      sio0, sio1;
  dbg_t            dbg0, dbg1;

  for (genvar g = 0; g < 4; g++) begin : g_m
    assign sio0[g] = m_oe[0][g] ? m_out[0][g] : 1'bz;
    assign sio1[g] = m_oe[1][g] ? m_out[1][g] : 1'bz;
  end

  spi_slave #(.SPI_MODE(0)) dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Bus_Mode(bus_mode[0]), .i_Lane_Dir(lane_dir[0]),
    .i_TX_Byte(tx_byte[0]), .i_TX_DV(tx_dv[0]), .o_TX_Ready(tx_ready[0]),
    .o_TX_Underrun(underrun[0]), .o_RX_Byte(rx_byte[0]), .o_RX_DV(rx_dv[0]),
    .o_Busy(busy[0]), .i_SPI_Clk(spi_clk[0]), .i_SPI_CS_n(cs_n[0]), .SIO(sio0),
    .o_Dbg(dbg0)
  );

  spi_slave #(.SPI_MODE(3)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_Bus_Mode(bus_mode[1]), .i_Lane_Dir(lane_dir[1]),
    .i_TX_Byte(tx_byte[1]), .i_TX_DV(tx_dv[1]), .o_TX_Ready(tx_ready[1]),
    .o_TX_Underrun(underrun[1]), .o_RX_Byte(rx_byte[1]), .o_RX_DV(rx_dv[1]),
    .o_Busy(busy[1]), .i_SPI_Clk(spi_clk[1]), .i_SPI_CS_n(cs_n[1]), .SIO(sio1),
    .o_Dbg(dbg1)
  );

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int total = 0;
  int bad = 0;
  int rx_cnt0 = 0;
  int rx_cnt1 = 0;
  int urun1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every RX_DV pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_dv[0]) begin
      rx_cnt0++;
      if (exp_q0.size() == 0) begin
        total++; bad++;
        $display("FAIL rx0_unexpected: got %0h want none", rx_byte[0]);
      end else check("rx0_byte", {24'b0, rx_byte[0]}, {24'b0, exp_q0.pop_front()});
    end
    if (rx_dv[1]) begin
      rx_cnt1++;
      if (exp_q1.size() == 0) begin
        total++; bad++;
        $display("FAIL rx1_unexpected: got %0h want none", rx_byte[1]);
      end else check("rx1_byte", {24'b0, rx_byte[1]}, {24'b0, exp_q1.pop_front()});
    end
    if (underrun[1]) urun1++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Half SPI period, accumulating every lane enable the slave shows meanwhile.
  task automatic half(input int sel, inout logic [3:0] acc);
    repeat (HALF) begin
      @(negedge clk);
      acc = acc | ((sel == 0) ? dbg0.sio_oe : dbg1.sio_oe);
    end
  endtask

  task automatic tx_load(input int sel, input logic [7:0] b);
    int k = 0;
    while (!tx_ready[sel] && k < 200) begin
      wait_clks(1);
      k++;
    end
    check("tx_ready_wait", {31'b0, tx_ready[sel]}, 32'd1);
    tx_byte[sel] = b;
    tx_dv[sel]   = 1'b1;
    wait_clks(1);
    tx_dv[sel]   = 1'b0;
  endtask

  task automatic put_bits(input int sel, input int lanes, input logic drv, input logic [7:0] sh);
    logic [3:0] o, e;
    if (lanes == 1)      begin o = {3'b000, sh[7]};  e = 4'b0001; end
    else if (lanes == 2) begin o = {2'b00, sh[7:6]}; e = 4'b0011; end
    else                 begin o = sh[7:4];          e = 4'b1111; end
    m_out[sel] = o;
    m_oe[sel]  = drv ? e : 4'b0000;
  endtask

  function automatic logic [7:0] cap_bits(input logic [7:0] c, input int lanes, input logic [3:0] s);
    if (lanes == 1) return {c[6:0], s[1]};
    if (lanes == 2) return {c[5:0], s[1:0]};
    return {c[3:0], s};
  endfunction

  // Master side: sel 0 is SPI mode 0, sel 1 is SPI mode 3; nedges clock pulses.
  task automatic xfer(input int sel, input int lanes, input int nedges, input logic drv,
                      input logic [7:0] mosi, output logic [7:0] miso, output logic [3:0] oe_or);
    logic [7:0] sh, c;
    logic [3:0] acc;
    sh = mosi; c = 8'h00; acc = 4'h0;
    for (int k = 0; k < nedges; k++) begin
      if (sel == 0) begin
        put_bits(0, lanes, drv, sh);
        half(0, acc);
        c = cap_bits(c, lanes, sio0);
        spi_clk[0] = 1'b1;
        half(0, acc);
        spi_clk[0] = 1'b0;
      end else begin
        spi_clk[1] = 1'b0;
        put_bits(1, lanes, drv, sh);
        half(1, acc);
        c = cap_bits(c, lanes, sio1);
        spi_clk[1] = 1'b1;
        half(1, acc);
      end
      sh = sh << lanes;
    end
    m_oe[sel] = 4'h0;
    miso  = c;
    oe_or = acc;
  endtask

  task automatic cs_low(input int sel);
    cs_n[sel] = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high(input int sel);
    cs_n[sel] = 1'b1;
    wait_clks(HALF);
  endtask

  initial begin
    logic [7:0] m;
    logic [3:0] oe;
    int base;
    rst = 1'b1;
    bus_mode = '0; lane_dir = '0; tx_dv = '0; tx_byte = '0;
    spi_clk = 2'b10; cs_n = 2'b11; m_out = '0; m_oe = '0;
    wait_clks(3);
    check("rst_tx_ready", {31'b0, tx_ready[0]}, 32'd1);
    check("rst_underrun", {31'b0, underrun[0]}, 32'd0);
    check("rst_rx_byte", {24'b0, rx_byte[0]}, 32'h00);
    check("rst_rx_dv", {31'b0, rx_dv[0]}, 32'd0);
    check("rst_busy", {31'b0, busy[0]}, 32'd0);
    check("rst_oe", {28'b0, dbg0.sio_oe}, 32'h0);
    check("rst_state", {31'b0, dbg0.state}, {31'b0, S_IDLE});
    check("rst_tx_ready3", {31'b0, tx_ready[1]}, 32'd1);
    rst = 1'b0;
    wait_clks(4);

    // Single lane, mode 0: A5 in, 3C out.
    tx_load(0, 8'h3C);
    check("t1_ready_low", {31'b0, tx_ready[0]}, 32'd0);
    bus_mode[0] = BUS_SINGLE;
    base = rx_cnt0;
    exp_q0.push_back(8'hA5);
    cs_low(0);
    check("t1_busy", {31'b0, busy[0]}, 32'd1);
    xfer(0, 1, 8, 1'b1, 8'hA5, m, oe);
    check("t1_miso", {24'b0, m}, 32'h3C);
    check("t1_oe", {28'b0, oe}, 32'h2);
    cs_high(0);
    check("t1_busy_off", {31'b0, busy[0]}, 32'd0);
    check("t1_oe_off", {28'b0, dbg0.sio_oe}, 32'h0);
    check("t1_ready", {31'b0, tx_ready[0]}, 32'd1);
    check("t1_rx_count", rx_cnt0 - base, 32'd1);

    // Mode 3, two bytes back to back, second byte underruns.
    tx_load(1, 8'h55);
    urun1 = 0;
    exp_q1.push_back(8'h12);
    exp_q1.push_back(8'h34);
    cs_low(1);
    xfer(1, 1, 8, 1'b1, 8'h12, m, oe);
    check("t2_miso0", {24'b0, m}, 32'h55);
    wait_clks(6);
    tx_load(1, 8'h00);
    xfer(1, 1, 8, 1'b1, 8'h34, m, oe);
    check("t2_miso1", {24'b0, m}, 32'hFF);
    cs_high(1);
    check("t2_underruns", urun1, 32'd1);
    check("t2_rx_count", rx_cnt1, 32'd2);

    // Dual lane, slave samples.
    bus_mode[0] = BUS_DUAL;
    lane_dir[0] = 1'b0;
    base = rx_cnt0;
    exp_q0.push_back(8'hC9);
    cs_low(0);
    xfer(0, 2, 4, 1'b1, 8'hC9, m, oe);
    check("t3_oe_never", {28'b0, oe}, 32'h0);
    cs_high(0);
    check("t3_rx_count", rx_cnt0 - base, 32'd1);

    // Quad lane, slave drives E7.
    tx_load(0, 8'hE7);
    bus_mode[0] = BUS_QUAD;
    lane_dir[0] = 1'b1;
    base = rx_cnt0;
    cs_low(0);
    xfer(0, 4, 2, 1'b0, 8'h00, m, oe);
    check("t4_miso", {24'b0, m}, 32'hE7);
    check("t4_oe", {28'b0, oe}, 32'hF);
    cs_high(0);
    check("t4_oe_off", {28'b0, dbg0.sio_oe}, 32'h0);
    check("t4_no_rx", rx_cnt0 - base, 32'd0);

    // Aborted byte, then a clean byte.
    bus_mode[0] = BUS_SINGLE;
    lane_dir[0] = 1'b0;
    base = rx_cnt0;
    cs_low(0);
    xfer(0, 1, 5, 1'b1, 8'hFF, m, oe);
    cs_high(0);
    check("t5_no_rx", rx_cnt0 - base, 32'd0);
    check("t5_oe_off", {28'b0, dbg0.sio_oe}, 32'h0);
    check("t5_state", {31'b0, dbg0.state}, {31'b0, S_IDLE});
    exp_q0.push_back(8'h81);
    cs_low(0);
    xfer(0, 1, 8, 1'b1, 8'h81, m, oe);
    cs_high(0);
    check("t5_rx_count", rx_cnt0 - base, 32'd1);

    // Reset in the middle of a byte.
    tx_load(0, 8'h3C);
    cs_low(0);
    xfer(0, 1, 3, 1'b1, 8'h00, m, oe);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_oe", {28'b0, dbg0.sio_oe}, 32'h0);
    check("t6_state", {31'b0, dbg0.state}, {31'b0, S_IDLE});
    check("t6_tx_ready", {31'b0, tx_ready[0]}, 32'd1);
    check("t6_rx_byte", {24'b0, rx_byte[0]}, 32'h00);
    check("t6_busy", {31'b0, busy[0]}, 32'd0);
    check("t6_rx_dv", {31'b0, rx_dv[0]}, 32'd0);
    wait_clks(3);
    cs_n[0] = 1'b1;
    rst = 1'b0;
    wait_clks(10);

    check("q0_empty", exp_q0.size(), 32'd0);
    check("q1_empty", exp_q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
